// File: rtl/regfile_write_arbiter_if.sv
// Register-file write request bundle: two valid/ready requesters plus the registered write port.
// The requester side (master) drives valid/reg/data; the arbiter side (slave) returns ready and the write port.
interface regfile_write_arbiter_if #(
    parameter int W = 32
);
    logic         req0_valid;
    logic [4:0]   req0_reg;
    logic [W-1:0] req0_data;
    logic         req0_ready;

    logic         req1_valid;
    logic [4:0]   req1_reg;
    logic [W-1:0] req1_data;
    logic         req1_ready;

    logic [4:0]   WriteReg;
    logic [W-1:0] WriteData;
    logic         RegWrite;
    logic         busy;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready,
        input  WriteReg, WriteData, RegWrite, busy
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready,
        output WriteReg, WriteData, RegWrite, busy
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester register-file write arbiter; zeroes x1..x31 after reset, then grants one write per cycle (latency 1).
// Ready is a same-cycle grant: lone requester wins, contention resolved by a toggling priority pointer; no buffering.
module regfile_write_arbiter #(
    parameter int W = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    regfile_write_arbiter_if.slave  bus
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic         prio_q, prio_d;
    logic         we_q, we_d;
    logic [4:0]   wreg_q, wreg_d;
    logic [W-1:0] wdata_q, wdata_d;

    logic         grant0;
    logic         grant1;
    logic         running;

    // Reset gates the grants so a request pending in the reset cycle is never accepted.
    assign running = (state_q == RUN) && !reset;
    assign grant0  = running && bus.req0_valid && (!bus.req1_valid || !prio_q);
    assign grant1  = running && bus.req1_valid && (!bus.req0_valid ||  prio_q);

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.busy       = (state_q == CLEAR);
    assign bus.RegWrite   = we_q;
    assign bus.WriteReg   = wreg_q;
    assign bus.WriteData  = wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        case (state_q)
            CLEAR: begin
                we_d    = 1'b1;
                wreg_d  = cnt_q;
                wdata_d = '0;
                // Counter parks at 31 rather than wrapping back to x0.
                if (cnt_q == 5'd31) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            RUN: begin
                if (grant0) begin
                    we_d    = (bus.req0_reg != 5'd0);
                    wreg_d  = bus.req0_reg;
                    wdata_d = bus.req0_data;
                    prio_d  = 1'b1;
                end else if (grant1) begin
                    we_d    = (bus.req1_reg != 5'd0);
                    wreg_d  = bus.req1_reg;
                    wdata_d = bus.req1_data;
                    prio_d  = 1'b0;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR;
            cnt_q   <= 5'd1;
            prio_q  <= 1'b0;
            we_q    <= 1'b0;
            wreg_q  <= 5'd0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            we_q    <= we_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: expected writes are queued when stimulus is applied
// and compared one edge later; scenario tasks add targeted checks on grants and register contents.
module tb_regfile_write_arbiter;

    typedef struct {
        logic        we;
        logic [4:0]  r;
        logic [31:0] d;
    } exp_t;

    logic clk;
    logic reset;
    regfile_write_arbiter_if #(.W(32)) rif ();

    regfile_write_arbiter #(.W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        m_run;
    logic        m_prio;
    logic [4:0]  m_cnt;
    logic [4:0]  m_last_reg;
    logic [31:0] m_last_data;
    logic [31:0] rf[32];
    logic        last_g0;
    logic        last_g1;
    int          wr_count;
    logic [4:0]  first_reg;

    task automatic set_req(input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                           input logic v1, input logic [4:0] r1, input logic [31:0] d1);
        rif.req0_valid = v0; rif.req0_reg = r0; rif.req0_data = d0;
        rif.req1_valid = v1; rif.req1_reg = r1; rif.req1_data = d1;
    endtask

    // One clock: check handshake against the model, queue the expected write, compare it after the edge.
    task automatic cycle();
        logic g0, g1;
        exp_t e, a;
        #1;
        g0 = !reset && m_run && rif.req0_valid && (!rif.req1_valid || m_prio == 1'b0);
        g1 = !reset && m_run && rif.req1_valid && (!rif.req0_valid || m_prio == 1'b1);
        n_checks++;
        if (rif.req0_ready !== g0) $display("FAIL req0_ready: got %b expected %b", rif.req0_ready, g0);
        else n_pass++;
        n_checks++;
        if (rif.req1_ready !== g1) $display("FAIL req1_ready: got %b expected %b", rif.req1_ready, g1);
        else n_pass++;
        n_checks++;
        if (rif.busy !== !m_run) $display("FAIL busy: got %b expected %b", rif.busy, !m_run);
        else n_pass++;
        last_g0 = rif.req0_ready;
        last_g1 = rif.req1_ready;

        if (reset) begin
            e = '{1'b0, 5'd0, 32'd0};
            m_run = 1'b0; m_cnt = 5'd1; m_prio = 1'b0;
        end else if (!m_run) begin
            e = '{1'b1, m_cnt, 32'd0};
            if (m_cnt == 5'd31) m_run = 1'b1;
            else m_cnt = m_cnt + 5'd1;
        end else if (g0) begin
            e = '{rif.req0_reg != 5'd0, rif.req0_reg, rif.req0_data};
            m_prio = 1'b1;
        end else if (g1) begin
            e = '{rif.req1_reg != 5'd0, rif.req1_reg, rif.req1_data};
            m_prio = 1'b0;
        end else begin
            e = '{1'b0, m_last_reg, m_last_data};
        end
        m_last_reg  = e.r;
        m_last_data = e.d;
        q.push_back(e);

        @(posedge clk);
        #1;
        n_checks++;
        if (q.size() == 0) begin
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            n_pass++;
            a = q.pop_front();
            n_checks++;
            if (rif.RegWrite !== a.we) $display("FAIL RegWrite: got %b expected %b", rif.RegWrite, a.we);
            else n_pass++;
            n_checks++;
            if (rif.WriteReg !== a.r) $display("FAIL WriteReg: got %0d expected %0d", rif.WriteReg, a.r);
            else n_pass++;
            n_checks++;
            if (rif.WriteData !== a.d) $display("FAIL WriteData: got %h expected %h", rif.WriteData, a.d);
            else n_pass++;
        end
        if (rif.RegWrite === 1'b1) begin
            rf[rif.WriteReg] = rif.WriteData;
            if (wr_count == 0) first_reg = rif.WriteReg;
            wr_count++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_req(1'b1, 5'd5, 32'h1234, 1'b1, 5'd6, 32'h5678);
        cycle();
        cycle();
    endtask

    task automatic test_clear();
        reset = 1'b0;
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        wr_count = 0;
        for (int i = 0; i < 31; i++) cycle();
        cycle();
        n_checks++;
        if (wr_count !== 31) $display("FAIL clear_count: got %0d expected 31", wr_count);
        else n_pass++;
        n_checks++;
        if (first_reg !== 5'd1) $display("FAIL clear_first: got %0d expected 1", first_reg);
        else n_pass++;
    endtask

    task automatic test_single();
        set_req(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        cycle();
        n_checks++;
        if (last_g0 !== 1'b1) $display("FAIL single_grant: got %b expected 1", last_g0);
        else n_pass++;
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_alternate();
        // Lone req1 transfer returns the pointer to requester 0.
        set_req(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        cycle();
        set_req(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        for (int i = 0; i < 4; i++) begin
            cycle();
            n_checks++;
            if (last_g0 !== ((i % 2) == 0) || last_g1 !== ((i % 2) == 1))
                $display("FAIL alternate_%0d: got g0=%b g1=%b expected g0=%b", i, last_g0, last_g1, (i % 2) == 0);
            else n_pass++;
            n_checks++;
            if (rif.RegWrite !== 1'b1) $display("FAIL alternate_write_%0d: got %b expected 1", i, rif.RegWrite);
            else n_pass++;
        end
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_same_reg();
        rf[7] = 32'hFFFF_FFFF;
        set_req(1'b1, 5'd7, 32'd1, 1'b1, 5'd7, 32'd2);
        cycle();
        set_req(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'd2);
        cycle();
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
        n_checks++;
        if (rf[7] !== 32'd2) $display("FAIL same_reg_readback: got %0d expected 2", rf[7]);
        else n_pass++;
    endtask

    task automatic test_zero_index();
        set_req(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0);
        cycle();
        set_req(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hABCD);
        cycle();
        n_checks++;
        if (last_g1 !== 1'b1 || rif.RegWrite !== 1'b0)
            $display("FAIL zero_index: got ready=%b RegWrite=%b expected ready=1 RegWrite=0", last_g1, rif.RegWrite);
        else n_pass++;
        set_req(1'b1, 5'd11, 32'hB, 1'b1, 5'd12, 32'hC);
        cycle();
        n_checks++;
        if (last_g0 !== 1'b1) $display("FAIL zero_prio: got g0=%b expected 1", last_g0);
        else n_pass++;
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle();
    endtask

    task automatic test_reset_run();
        set_req(1'b1, 5'd13, 32'h1313, 1'b0, 5'd0, 32'd0);
        reset = 1'b1;
        cycle();
        n_checks++;
        if (last_g0 !== 1'b0) $display("FAIL reset_run_ready: got %b expected 0", last_g0);
        else n_pass++;
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic test_clear_restart();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        wr_count = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (rif.busy !== 1'b1) break;
        end
        n_checks++;
        if (wr_count !== 31) $display("FAIL restart_count: got %0d expected 31", wr_count);
        else n_pass++;
        n_checks++;
        if (first_reg !== 5'd1) $display("FAIL restart_first: got %0d expected 1", first_reg);
        else n_pass++;
        cycle();
    endtask

    initial begin
        reset = 1'b1;
        set_req(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        m_run = 1'b0; m_cnt = 5'd1; m_prio = 1'b0;
        m_last_reg = 5'd0; m_last_data = 32'd0;
        wr_count = 0; first_reg = 5'd0;
        last_g0 = 1'b0; last_g1 = 1'b0;
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_clear();
        test_single();
        test_alternate();
        test_same_reg();
        test_zero_index();
        test_reset_run();
        test_clear_restart();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
